gray_count_decoder: RTL and testbench

- Receive-side companion to the team's Gray-code counter: samples a WIDTH-bit Gray count, decodes it to binary and classifies each sample-to-sample step as up, down, hold or illegal.
- Sits at the consumer end of a Gray-count link, e.g. a position/pointer bus or a counter output fanned to another block.
- Tracks lock status and counts illegal transitions, so a bench or system can confirm the counter obeys the one-bit-change rule.

---
 rtl/gray_pkg.sv | 17 +
 rtl/gray2bin.sv | 15 +
 rtl/gray_count_decoder.sv | 149 ++++++++++++++
 tb/tb_gray_count_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-count receive path.
package gray_pkg;

  // Lock-tracking states of the decoder.
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // Classification of one sample-to-sample step.
  localparam logic [1:0] STEP_HOLD = 2'd0;
  localparam logic [1:0] STEP_UP   = 2'd1;
  localparam logic [1:0] STEP_DOWN = 2'd2;
  localparam logic [1:0] STEP_ERR  = 2'd3;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at and above its position.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB down.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_count_decoder.sv
// Samples a Gray count, decodes it to binary and classifies each step as
// up, down, hold or illegal, while tracking lock and counting illegal steps.
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_gray;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_bin;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] delta;
  logic [1:0]       step_class;
  state_t           state, state_nxt;
  logic [GW-1:0]    good_cnt, good_nxt;
  logic             up_nxt, down_nxt, err_nxt;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (s1_gray),
    .bin  (dec_bin)
  );

  // Capture the raw sample, then the decoded value one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_gray  <= '0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
    end else begin
      s1_valid <= gray_valid;
      if (gray_valid) s1_gray <= gray_in;
      s2_valid <= s1_valid;
      if (s1_valid) s2_bin <= dec_bin;
    end
  end

  // Classify the step by the modular distance from the previous sample.
  always_comb begin
    delta = s2_bin - prev_bin;
    if (delta == '0)                 step_class = STEP_HOLD;
    else if (delta == WIDTH'(1))     step_class = STEP_UP;
    else if (delta == {WIDTH{1'b1}}) step_class = STEP_DOWN;
    else                             step_class = STEP_ERR;
  end

  // Lock FSM next state and step flags for the sample now in stage 2.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    up_nxt    = 1'b0;
    down_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (s2_valid) begin
      if (state != ACQUIRE) begin
        up_nxt   = (step_class == STEP_UP);
        down_nxt = (step_class == STEP_DOWN);
        err_nxt  = (step_class == STEP_ERR);
      end
      case (state)
        ACQUIRE: begin
          state_nxt = TRACK;
          good_nxt  = '0;
        end
        TRACK: begin
          if (step_class == STEP_ERR) begin
            state_nxt = FAULT;
            good_nxt  = '0;
          end
        end
        FAULT: begin
          if (step_class == STEP_ERR) begin
            good_nxt = '0;
          end else if (step_class != STEP_HOLD) begin
            if (good_cnt >= GW'(LOCK_CNT - 1)) begin
              state_nxt = TRACK;
              good_nxt  = '0;
            end else begin
              good_nxt = good_cnt + GW'(1);
            end
          end
        end
        default: begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      endcase
    end
  end

  // Output register; flags and bin_out hold between accepted samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_valid <= 1'b0;
      bin_out   <= '0;
      prev_bin  <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      step_err  <= 1'b0;
      state     <= ACQUIRE;
      good_cnt  <= '0;
    end else begin
      bin_valid <= s2_valid;
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      if (s2_valid) begin
        bin_out   <= s2_bin;
        prev_bin  <= s2_bin;
        step_up   <= up_nxt;
        step_down <= down_nxt;
        step_err  <= err_nxt;
      end
    end
  end

  // Saturating illegal-step counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (s2_valid && err_nxt && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed self-checking bench for gray_count_decoder: main instance with
// default widths plus a 2-bit error counter instance for saturation checks.
module tb_gray_count_decoder;

  logic       clk;
  logic       reset_n;
  logic [3:0] gray_in;
  logic       gray_valid;
  logic       err_clr;

  logic [3:0] bin_out, bin_out2;
  logic       bin_valid, bin_valid2;
  logic       step_up, step_up2;
  logic       step_down, step_down2;
  logic       step_err, step_err2;
  logic       locked, locked2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int tests_run = 0;
  int tests_failed = 0;

  gray_count_decoder #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gray_in    (gray_in),
    .gray_valid (gray_valid),
    .err_clr    (err_clr),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_up    (step_up),
    .step_down  (step_down),
    .step_err   (step_err),
    .locked     (locked),
    .err_count  (err_count)
  );

  gray_count_decoder #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(2)) dut_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .gray_in    (gray_in),
    .gray_valid (gray_valid),
    .err_clr    (err_clr),
    .bin_out    (bin_out2),
    .bin_valid  (bin_valid2),
    .step_up    (step_up2),
    .step_down  (step_down2),
    .step_err   (step_err2),
    .locked     (locked2),
    .err_count  (err_count2)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one clock edge and return at the following falling edge.
  task automatic applyStimulus(input logic v, input logic [3:0] g, input logic clr);
    gray_valid = v;
    gray_in    = g;
    err_clr    = clr;
    @(negedge clk);
  endtask

  // Compare the main instance's pulse, value, flags and lock status.
  task automatic checkOutput(input string tag, input logic v, input logic [3:0] b,
                             input logic up, input logic dn, input logic er,
                             input logic lk);
    chk({tag, ".valid"}, 32'(bin_valid), 32'(v));
    chk({tag, ".bin"},   32'(bin_out),   32'(b));
    chk({tag, ".up"},    32'(step_up),   32'(up));
    chk({tag, ".down"},  32'(step_down), 32'(dn));
    chk({tag, ".err"},   32'(step_err),  32'(er));
    chk({tag, ".lock"},  32'(locked),    32'(lk));
  endtask

  // One isolated sample; its result is visible after the two idle cycles.
  task automatic feed(input logic [3:0] g, input logic clr);
    applyStimulus(1'b1, g, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, clr);
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0);
  endtask

  // Linear directed sequence.
  initial begin
    reset_n    = 1'b0;
    gray_in    = 4'h0;
    gray_valid = 1'b0;
    err_clr    = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.errcnt", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0);

    // Back-to-back count 0..3.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    chk("b2b.lat1", 32'(bin_valid), 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    chk("b2b.lat2", 32'(bin_valid), 32'd0);
    applyStimulus(1'b1, 4'b0011, 1'b0);
    checkOutput("b2b0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkOutput("b2b1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("b2b2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("b2b3", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    chk("b2b.idle", 32'(bin_valid), 32'd0);
    chk("b2b.hold", 32'(bin_out), 32'd3);

    // Wrap up through 15 -> 0, then down 0 -> 15.
    do_reset();
    feed(4'b1001, 1'b0);
    checkOutput("wrap14", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    feed(4'b1000, 1'b0);
    checkOutput("wrap15", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    feed(4'b0000, 1'b0);
    checkOutput("wrap0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    feed(4'b1000, 1'b0);
    checkOutput("down15", 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wrap.errcnt", 32'(err_count), 32'd0);

    // Climb to 2, then hold three times.
    feed(4'b0000, 1'b0);
    feed(4'b0001, 1'b0);
    feed(4'b0011, 1'b0);
    checkOutput("climb2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      feed(4'b0011, 1'b0);
      checkOutput("hold", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Down to 0, illegal 0 -> 2, then four ups to relock.
    feed(4'b0001, 1'b0);
    checkOutput("dn1", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    feed(4'b0000, 1'b0);
    checkOutput("dn0", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    feed(4'b0011, 1'b0);
    checkOutput("jump", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("jump.errcnt", 32'(err_count), 32'd1);
    feed(4'b0010, 1'b0);
    checkOutput("relock3", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(4'b0110, 1'b0);
    checkOutput("relock4", 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(4'b0111, 1'b0);
    checkOutput("relock5", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(4'b0101, 1'b0);
    checkOutput("relock6", 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("relock.errcnt", 32'(err_count), 32'd1);

    // Saturation of the 2-bit counter, then clear against a new error.
    do_reset();
    feed(4'b0000, 1'b0);
    feed(4'b0011, 1'b0);
    feed(4'b0000, 1'b0);
    feed(4'b0011, 1'b0);
    chk("sat.three", 32'(err_count2), 32'd3);
    feed(4'b0000, 1'b0);
    feed(4'b0011, 1'b0);
    chk("sat.hold", 32'(err_count2), 32'd3);
    chk("sat.err", 32'(step_err2), 32'd1);
    chk("sat.main", 32'(err_count), 32'd5);
    feed(4'b0000, 1'b1);
    chk("clr.err", 32'(step_err2), 32'd1);
    chk("clr.cnt2", 32'(err_count2), 32'd0);
    chk("clr.cnt", 32'(err_count), 32'd0);
    chk("clr.lock", 32'(locked2), 32'd0);

    // Reset with two samples in flight.
    feed(4'b0001, 1'b0);
    checkOutput("pre", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(4'b0011, 1'b0);
    chk("pre.cnt", 32'(err_count), 32'd0);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    gray_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'h0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0);
      chk("post.novalid", 32'(bin_valid), 32'd0);
    end
    feed(4'b1100, 1'b0);
    checkOutput("reacq", 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reacq.cnt", 32'(err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
